// File: rtl/async_fifo_stage.sv
// Request/acknowledge FIFO stage: upstream words land in a circular buffer and are
// delivered one per acknowledge pulse once every downstream consumer is requesting.
module async_fifo_stage #(
  parameter int data_width  = 32,
  parameter int depth       = 4,
  parameter int output_size = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        req_l,
  input  logic                        ack_l,
  input  logic [data_width-1:0]       din_l,
  input  logic [output_size-1:0]      req_r,
  output logic                        ack_r,
  output logic [data_width-1:0]       dout_r,
  output logic [$clog2(depth):0]      occupancy,
  output logic                        overflow
);

  localparam int ptr_w = $clog2(depth);
  localparam int occ_w = ptr_w + 1;
  localparam logic [occ_w-1:0] full_count = occ_w'(depth);

  logic [data_width-1:0] mem [depth];
  logic [ptr_w-1:0]      wr_ptr;
  logic [ptr_w-1:0]      rd_ptr;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic [occ_w-1:0]      occ_next;

  // Pops are gated on !ack_r so a consumer sees at most one pulse every two cycles.
  always_comb begin
    full     = (occupancy == full_count);
    push     = ack_l && !full;
    pop      = (&req_r) && !ack_r && (occupancy != '0);
    occ_next = occupancy;
    if (push && !pop) occ_next = occupancy + occ_w'(1);
    else if (pop && !push) occ_next = occupancy - occ_w'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_l     <= 1'b0;
      ack_r     <= 1'b0;
      dout_r    <= '0;
      occupancy <= '0;
      overflow  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      // NOTE: every register here uses <= so all of them see the same pre-edge values.
      req_l     <= !ack_l && (occ_next < full_count);
      ack_r     <= pop;
      occupancy <= occ_next;
      if (ack_l && full) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + ptr_w'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_w'(1);
        dout_r <= mem[rd_ptr];
      end
    end
  end

  // NOTE: the storage array has no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= din_l;
  end

endmodule

// File: doc/async_fifo_stage.md
ASYNC_FIFO_STAGE -- requirements
Module: async_fifo_stage

Interface
REQ-001 Parameter data_width, default 32, width of every data word.
REQ-002 Parameter depth, default 4, number of buffered entries; power of two, at least 2.
REQ-003 Parameter output_size, default 1, number of downstream consumers sharing the output.
REQ-004 Port clk  input  1  clock; all state changes on the rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port req_l  output  1  request to the upstream node, registered.
REQ-007 Port ack_l  input  1  one-cycle upstream acknowledge; din_l is valid in the same cycle.
REQ-008 Port din_l  input  data_width  upstream data.
REQ-009 Port req_r  input  output_size  requests from the downstream consumers.
REQ-010 Port ack_r  output  1  one-cycle acknowledge to downstream, registered.
REQ-011 Port dout_r  output  data_width  delivered word, registered, held until the next delivery.
REQ-012 Port occupancy  output  log2(depth)+1  number of stored entries.
REQ-013 Port overflow  output  1  sticky error flag.

Function
REQ-014 Storage SHALL be a circular buffer with read and write pointers of log2(depth) bits that wrap from depth-1 to 0.
REQ-015 When ack_l=1 and occupancy<depth, din_l SHALL be written at the write pointer on that edge, and the write pointer SHALL advance.
REQ-016 When ack_l=1 and occupancy=depth, the word SHALL be discarded, the stored contents SHALL be unchanged, and overflow SHALL be set to 1 until reset.
REQ-017 req_l next value SHALL be 1 if and only if ack_l=0 in the current cycle and the post-edge occupancy is less than depth. This gives a one-cycle request gap after every acknowledge.
REQ-018 A pop SHALL occur on an edge where all req_r bits are 1, ack_r=0, and the pre-edge occupancy is greater than 0.
REQ-019 On a pop, ack_r SHALL become 1, dout_r SHALL take the head entry, and the read pointer SHALL advance.
REQ-020 In every other cycle, ack_r SHALL return to 0. ack_r is never high for two consecutive cycles.
REQ-021 If a push and a pop occur on the same edge, occupancy SHALL be unchanged and both pointers SHALL advance.
REQ-022 There SHALL be no bypass. The minimum latency is 2 cycles: ack_l in cycle t gives ack_r in cycle t+2.
REQ-023 Maximum throughput SHALL be one word every 2 cycles on each side.
REQ-024 Words SHALL be delivered in strict FIFO order, bit-exact.
REQ-025 With partial req_r, no pop SHALL occur and the data SHALL be retained.

Reset
REQ-026 While rst=1, the block SHALL hold:
- req_l=0, ack_r=0, dout_r=0, occupancy=0, overflow=0
- both pointers at 0
- ack_l ignored
REQ-027 Reset asserted mid-operation SHALL discard all stored entries. The first post-reset delivery SHALL be the first post-reset push.
REQ-028 req_l SHALL rise on the first edge after rst deasserts.

Verification
REQ-029 Reset release -> req_l=1 after one cycle; ack_r=0, dout_r=0, occupancy=0.
REQ-030 depth=4, req_r=0, push 5,6,7,8 -> occupancy=4 and req_l=0 with no ack_r. Then req_r=1 -> ack_r pulses on alternate cycles with dout_r 5,6,7,8, and req_l reasserts after the first pop.
REQ-031 Empty buffer, req_r=1, ack_l with 0x2A in cycle t -> ack_r=1 only in cycle t+2, with dout_r=0x2A held afterwards.
REQ-032 output_size=2, one stored word -> req_r=2'b01 gives no ack_r for 10 cycles; 2'b11 gives one ack_r pulse.
REQ-033 Full buffer, forced ack_l with 0xFF -> overflow=1, occupancy stays 4, and later deliveries omit 0xFF.
REQ-034 3 entries stored, rst pulsed for one cycle -> occupancy=0, overflow=0, and the next delivery is the first post-reset push.
